alu_issue_stage: RTL and testbench

//  Issue stage directly upstream of the integer ALU. Accepts decoded ALU ops over a valid/ready

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_fwd_match.sv | 23 ++
 rtl/alu_issue_stage.sv | 160 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: function codes, FSM states and the buffered entry.
// Entry widths follow ALU_DATA_W/ALU_REG_W; the top's DATA_WIDTH/REG_ADDR_W must match them.
package alu_pkg;

    localparam int ALU_DATA_W = 64;
    localparam int ALU_REG_W  = 5;

    typedef enum logic [4:0] {
        ALU_ADDU = 5'd0,
        ALU_ADD,
        ALU_SUBU,
        ALU_SUB,
        ALU_XOR,
        ALU_AND,
        ALU_OR,
        ALU_SLTU,
        ALU_SLT,
        ALU_NEG
    } alu_func_e;

    localparam logic [4:0] ALU_FUNC_MAX = 5'd9;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } issue_state_e;

    // b is the already-selected operand B (imm or rs2), so the ALU sees a plain register.
    typedef struct packed {
        logic [4:0]            func;
        logic [ALU_REG_W-1:0]  rs1_addr;
        logic [ALU_REG_W-1:0]  rs2_addr;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b_raw;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_DATA_W-1:0] imm;
        logic                  use_imm;
        logic [ALU_REG_W-1:0]  rd;
    } issue_entry_t;

    function automatic logic func_illegal(input logic [4:0] func);
        return func > ALU_FUNC_MAX;
    endfunction

endpackage

// File: rtl/alu_fwd_match.sv
// Single-operand writeback snoop: substitutes wb_data when the writeback targets this
// source register; register 0 never matches. Purely combinational.
module alu_fwd_match
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_W,
    parameter int REG_ADDR_W = ALU_REG_W
) (
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic hit;

    assign hit      = en && wb_valid && (wb_rd_addr == src_addr) && (src_addr != '0);
    assign data_out = hit ? wb_data : src_data;

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry (head + skid) issue buffer feeding the integer ALU; 1-cycle latency when empty.
// in_ready drops only when the skid is full, never from out_ready; ALU_ISSUE_FWD_EN enables wb forwarding.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_W,
    parameter int REG_ADDR_W = ALU_REG_W,
    parameter int SHIFT_AMT  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_func_code,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_data_a,
    output logic [DATA_WIDTH-1:0] alu_data_b,
    output logic [SHIFT_AMT-1:0]  alu_shift_code,
    output logic [4:0]            alu_func_code,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_illegal
);

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    issue_state_e state_q, state_d;
    issue_entry_t head_q, head_d;
    issue_entry_t skid_q, skid_d;

    logic accept;
    logic pop;

    // Source 0 is the incoming op, 1 the head, 2 the skid; all snoop the same wb bus.
    issue_entry_t          src_ent [3];
    issue_entry_t          fwd_ent [3];
    logic [DATA_WIDTH-1:0] a_fwd   [3];
    logic [DATA_WIDTH-1:0] b_fwd   [3];

    always_comb begin
        src_ent[0]          = '0;
        src_ent[0].func     = in_func_code;
        src_ent[0].rs1_addr = in_rs1_addr;
        src_ent[0].rs2_addr = in_rs2_addr;
        src_ent[0].a        = in_rs1_data;
        src_ent[0].b_raw    = in_rs2_data;
        src_ent[0].imm      = in_imm;
        src_ent[0].use_imm  = in_use_imm;
        src_ent[0].rd       = in_rd_addr;
        src_ent[1]          = head_q;
        src_ent[2]          = skid_q;
    end

    for (genvar g = 0; g < 3; g++) begin : g_fwd
        alu_fwd_match #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_rs1_match (
            .en         (FWD_EN),
            .src_addr   (src_ent[g].rs1_addr),
            .src_data   (src_ent[g].a),
            .wb_valid   (wb_valid),
            .wb_rd_addr (wb_rd_addr),
            .wb_data    (wb_data),
            .data_out   (a_fwd[g])
        );

        alu_fwd_match #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_rs2_match (
            .en         (FWD_EN && !src_ent[g].use_imm),
            .src_addr   (src_ent[g].rs2_addr),
            .src_data   (src_ent[g].b_raw),
            .wb_valid   (wb_valid),
            .wb_rd_addr (wb_rd_addr),
            .wb_data    (wb_data),
            .data_out   (b_fwd[g])
        );
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fwd_ent[i]       = src_ent[i];
            fwd_ent[i].a     = a_fwd[i];
            fwd_ent[i].b_raw = b_fwd[i];
            fwd_ent[i].b     = src_ent[i].use_imm ? src_ent[i].imm : b_fwd[i];
        end
    end

    assign in_ready  = !rst && (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = fwd_ent[1];
        skid_d  = fwd_ent[2];
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = fwd_ent[0];
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    head_d = fwd_ent[0];
                end else if (accept) begin
                    skid_d  = fwd_ent[0];
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = fwd_ent[2];
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign alu_data_a     = head_q.a;
    assign alu_data_b     = head_q.b;
    assign alu_shift_code = head_q.b[SHIFT_AMT-1:0];
    assign alu_func_code  = head_q.func;
    assign out_rd_addr    = head_q.rd;
    assign out_illegal    = func_illegal(head_q.func);

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_func_code;
    logic [4:0]  in_rs1_addr;
    logic [63:0] in_rs1_data;
    logic [4:0]  in_rs2_addr;
    logic [63:0] in_rs2_data;
    logic [63:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd_addr;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_data_a;
    logic [63:0] alu_data_b;
    logic [5:0]  alu_shift_code;
    logic [4:0]  alu_func_code;
    logic [4:0]  out_rd_addr;
    logic        out_illegal;

    alu_issue_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_func_code   (in_func_code),
        .in_rs1_addr    (in_rs1_addr),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_addr    (in_rs2_addr),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_use_imm     (in_use_imm),
        .in_rd_addr     (in_rd_addr),
        .wb_valid       (wb_valid),
        .wb_rd_addr     (wb_rd_addr),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_data_a     (alu_data_a),
        .alu_data_b     (alu_data_b),
        .alu_shift_code (alu_shift_code),
        .alu_func_code  (alu_func_code),
        .out_rd_addr    (out_rd_addr),
        .out_illegal    (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  func;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] a;
        logic [63:0] b_raw;
        logic [63:0] imm;
        logic        use_imm;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;

    function automatic logic [63:0] model_fwd(input logic [4:0] addr, input logic [63:0] d,
                                              input logic en);
        if (FWD && en && wb_valid && (wb_rd_addr == addr) && (addr != 5'd0))
            return wb_data;
        return d;
    endfunction

    // Scoreboard: compare the head on each pop, then age held entries and capture new ones.
    always @(negedge clk) begin
        exp_t        e;
        exp_t        h;
        logic [63:0] eb;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_issue: got rd=%0d with empty scoreboard", out_rd_addr);
                end else begin
                    e  = sb_q.pop_front();
                    eb = e.use_imm ? e.imm : e.b_raw;
                    n_out++;
                    if ({alu_data_a, alu_data_b, alu_shift_code, alu_func_code, out_rd_addr, out_illegal}
                        !== {e.a, eb, eb[5:0], e.func, e.rd, (e.func > 5'd9)}) begin
                        bad++;
                        $display("FAIL sb_issue: got a=%h b=%h sh=%h f=%0d rd=%0d ill=%b want a=%h b=%h sh=%h f=%0d rd=%0d ill=%b",
                                 alu_data_a, alu_data_b, alu_shift_code, alu_func_code, out_rd_addr, out_illegal,
                                 e.a, eb, eb[5:0], e.func, e.rd, (e.func > 5'd9));
                    end
                end
            end
            for (int i = 0; i < sb_q.size(); i++) begin
                h       = sb_q[i];
                h.a     = model_fwd(h.rs1, h.a, 1'b1);
                h.b_raw = model_fwd(h.rs2, h.b_raw, !h.use_imm);
                sb_q[i] = h;
            end
            if (in_valid && in_ready) begin
                e.func    = in_func_code;
                e.rs1     = in_rs1_addr;
                e.rs2     = in_rs2_addr;
                e.rd      = in_rd_addr;
                e.imm     = in_imm;
                e.use_imm = in_use_imm;
                e.a       = model_fwd(in_rs1_addr, in_rs1_data, 1'b1);
                e.b_raw   = model_fwd(in_rs2_addr, in_rs2_data, !in_use_imm);
                sb_q.push_back(e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] f, input logic [4:0] rs1, input logic [63:0] d1,
                          input logic [4:0] rs2, input logic [63:0] d2, input logic [63:0] imm,
                          input logic ui, input logic [4:0] rd);
        in_valid     = 1'b1;
        in_func_code = f;
        in_rs1_addr  = rs1;
        in_rs1_data  = d1;
        in_rs2_addr  = rs2;
        in_rs2_data  = d2;
        in_imm       = imm;
        in_use_imm   = ui;
        in_rd_addr   = rd;
    endtask

    task automatic drain;
        in_valid  = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (sb_q.size() != 0 || out_valid); k++) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_op(5'd1, 5'd1, 64'h1, 5'd2, 64'h2, 64'h3, 1'b0, 5'd4);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if ({out_valid, in_ready, alu_data_a, alu_data_b, out_rd_addr, out_illegal} !== '0) begin
                bad++;
                $display("FAIL reset_hold: got out_valid=%b in_ready=%b a=%h b=%h rd=%0d want all zero",
                         out_valid, in_ready, alu_data_a, alu_data_b, out_rd_addr);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_stream;
        int base;
        base      = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_op(5'(i), 5'(i + 1), {$urandom, $urandom}, 5'(i + 9), {$urandom, $urandom},
                   {$urandom, $urandom}, i[0], 5'(i + 1));
            tick();
            if (i == 0) begin
                total++;
                if ({out_valid, out_rd_addr} !== {1'b1, 5'd1}) begin
                    bad++;
                    $display("FAIL stream_latency: got out_valid=%b rd=%0d want 1 1", out_valid, out_rd_addr);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (n_out - base !== 8) begin
            bad++;
            $display("FAIL stream_throughput: got %0d issues want 8", n_out - base);
        end
        drain();
        total++;
        if (sb_q.size() !== 0) begin
            bad++;
            $display("FAIL stream_drain: got %0d pending want 0", sb_q.size());
        end
    endtask

    task automatic test_stall;
        int base;
        base      = n_out;
        out_ready = 1'b0;
        set_op(5'd0, 5'd1, 64'hA1, 5'd2, 64'hB1, 64'h0, 1'b0, 5'd1);
        tick();
        set_op(5'd3, 5'd3, 64'hA2, 5'd4, 64'hB2, 64'h0, 1'b0, 5'd2);
        tick();
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_full_ready: got in_ready=%b want 0", in_ready);
        end
        set_op(5'd4, 5'd5, 64'hA3, 5'd6, 64'hB3, 64'h0, 1'b0, 5'd3);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({in_ready, out_valid, out_rd_addr, alu_data_a} !== {1'b0, 1'b1, 5'd1, 64'hA1}) begin
                bad++;
                $display("FAIL stall_hold: got in_ready=%b out_valid=%b rd=%0d a=%h want 0 1 1 a1",
                         in_ready, out_valid, out_rd_addr, alu_data_a);
            end
        end
        out_ready = 1'b1;
        tick();
        total++;
        if ({in_ready, out_rd_addr} !== {1'b1, 5'd2}) begin
            bad++;
            $display("FAIL stall_release: got in_ready=%b rd=%0d want 1 2", in_ready, out_rd_addr);
        end
        tick();
        drain();
        total++;
        if ((n_out - base !== 3) || (sb_q.size() !== 0)) begin
            bad++;
            $display("FAIL stall_order_count: got %0d issues %0d pending want 3 0", n_out - base, sb_q.size());
        end
    endtask

    task automatic test_fwd;
        logic [63:0] exp_a;
        out_ready  = 1'b1;
        set_op(5'd1, 5'd5, 64'h10, 5'd3, 64'h1, 64'h0, 1'b0, 5'd20);
        wb_valid   = 1'b1;
        wb_rd_addr = 5'd5;
        wb_data    = 64'hAB;
        exp_a      = FWD ? 64'hAB : 64'h10;
        tick();
        total++;
        if (alu_data_a !== exp_a) begin
            bad++;
            $display("FAIL fwd_rs1_capture: got a=%h want %h", alu_data_a, exp_a);
        end
        set_op(5'd1, 5'd0, 64'h22, 5'd3, 64'h1, 64'h0, 1'b0, 5'd21);
        wb_rd_addr = 5'd0;
        wb_data    = 64'hCC;
        tick();
        total++;
        if (alu_data_a !== 64'h22) begin
            bad++;
            $display("FAIL fwd_reg0: got a=%h want 22", alu_data_a);
        end
        drain();
    endtask

    task automatic test_skid_fwd;
        logic [63:0] exp_b;
        logic [5:0]  exp_sh;
        out_ready = 1'b0;
        wb_valid  = 1'b0;
        set_op(5'd0, 5'd1, 64'h1, 5'd7, 64'h77, 64'h3C, 1'b1, 5'd10);
        tick();
        set_op(5'd0, 5'd2, 64'h2, 5'd7, 64'h99, 64'h3, 1'b0, 5'd11);
        tick();
        in_valid   = 1'b0;
        wb_valid   = 1'b1;
        wb_rd_addr = 5'd7;
        wb_data    = 64'h55;
        tick();
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        exp_b  = FWD ? 64'h55 : 64'h99;
        exp_sh = FWD ? 6'h15 : 6'h19;
        total++;
        if ({out_valid, out_rd_addr, alu_data_b, alu_shift_code} !== {1'b1, 5'd11, exp_b, exp_sh}) begin
            bad++;
            $display("FAIL skid_fwd_rs2: got v=%b rd=%0d b=%h sh=%h want 1 11 %h %h",
                     out_valid, out_rd_addr, alu_data_b, alu_shift_code, exp_b, exp_sh);
        end
        drain();
    endtask

    task automatic test_illegal_reset;
        out_ready = 1'b1;
        set_op(5'b01010, 5'd1, 64'h5, 5'd2, 64'h6, 64'h0, 1'b0, 5'd12);
        tick();
        total++;
        if ({out_valid, out_illegal} !== 2'b11) begin
            bad++;
            $display("FAIL illegal_10: got out_valid=%b illegal=%b want 1 1", out_valid, out_illegal);
        end
        set_op(5'd9, 5'd1, 64'h5, 5'd2, 64'h6, 64'h0, 1'b0, 5'd13);
        tick();
        total++;
        if ({out_illegal, out_rd_addr} !== {1'b0, 5'd13}) begin
            bad++;
            $display("FAIL legal_9: got illegal=%b rd=%0d want 0 13", out_illegal, out_rd_addr);
        end
        drain();
        out_ready = 1'b0;
        set_op(5'd2, 5'd1, 64'h5, 5'd2, 64'h6, 64'h0, 1'b0, 5'd14);
        tick();
        set_op(5'd2, 5'd1, 64'h7, 5'd2, 64'h8, 64'h0, 1'b0, 5'd15);
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        total++;
        if ({out_valid, in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_full: got out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_full_empty: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        int   base;
        int   guard;
        logic acc;
        base = n_out;
        for (int i = 0; i < 40; i++) begin
            set_op(5'($urandom_range(0, 11)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                   5'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 5'(i));
            guard = 0;
            do begin
                out_ready  = 1'($urandom_range(0, 1));
                wb_valid   = 1'($urandom_range(0, 1));
                wb_rd_addr = 5'($urandom_range(0, 7));
                wb_data    = {$urandom, $urandom};
                acc        = in_ready;
                tick();
                guard++;
            end while (!acc && guard < 50);
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL b2b_accept_timeout: op %0d not accepted in 50 cycles", i);
            end
        end
        drain();
        total++;
        if ((n_out - base !== 40) || (sb_q.size() !== 0)) begin
            bad++;
            $display("FAIL b2b_count: got %0d issues %0d pending want 40 0", n_out - base, sb_q.size());
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_func_code = '0;
        in_rs1_addr  = '0;
        in_rs1_data  = '0;
        in_rs2_addr  = '0;
        in_rs2_data  = '0;
        in_imm       = '0;
        in_use_imm   = 1'b0;
        in_rd_addr   = '0;
        wb_valid     = 1'b0;
        wb_rd_addr   = '0;
        wb_data      = '0;
        out_ready    = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_fwd();
        test_skid_fwd();
        test_illegal_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
